mux_rr_nto1: RTL and testbench

//   Parametrised N:1 data selector with registered output, valid/ready handshakes
//   and built-in arbitration (round-robin or fixed priority). Merges several
//   32-bit-class producers (e.g. writeback/forwarding sources, memory requesters)

---
 rtl/mux_rr_nto1.sv | 56 +++++
 tb/tb_mux_rr_nto1.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N:1 registered selector with valid/ready handshakes and round-robin or fixed-priority arbitration
module mux_rr_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [SELW-1:0] ptr, gidx;
    logic load;
    function automatic logic [SELW-1:0] cand(input logic [SELW-1:0] p, input int k);
        return SELW'((MODE == 0 ? int'(p) + k : k) % N);
    endfunction
    // grant: walk the search order backwards so the earliest valid candidate wins
    always_comb begin
        gidx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[cand(ptr, k)]) gidx = cand(ptr, k);
        end
    end
    assign out_valid = (state == FULL);
    assign load      = (~out_valid | out_ready) & (|in_valid);
    assign in_ready  = load ? (N'(1) << gidx) : '0;
    // next state: refill wins over drain, drain empties, otherwise hold
    always_comb begin
        state_nx = load ? FULL : (out_ready ? EMPTY : state);
    end
    // output stage occupancy
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end
    // data/index capture and pointer advance on every accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (load) begin
            out_data <= in_data[int'(gidx)*WIDTH +: WIDTH];
            out_sel  <= gidx;
            if (MODE == 0) ptr <= (gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: scoreboard bench for round-robin and fixed-priority instances
module tb_mux_rr_nto1;
    logic clk = 1'b0, rst = 1'b1, ordy = 1'b0;
    logic [3:0] v0 = '0, v1 = '0, rdy0, rdy1;
    logic [31:0] d [4];
    logic [127:0] din;
    logic ov0, ov1;
    logic [31:0] od0, od1;
    logic [1:0] os0, os1;
    logic [33:0] q0 [$], q1 [$];
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;
    always_comb din = {d[3], d[2], d[1], d[0]};

    mux_rr_nto1 #(.WIDTH(32), .N(4), .MODE(0), .SELW(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(din), .in_ready(rdy0),
        .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy));
    mux_rr_nto1 #(.WIDTH(32), .N(4), .MODE(1), .SELW(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(din), .in_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2i(input logic [3:0] oh);
        logic [1:0] r = '0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // one cycle of stimulus: drive, check in_ready against the hand value, log expected output
    task automatic step(input logic [3:0] a0, input logic [3:0] a1, input logic r,
                        input logic [3:0] e0, input logic [3:0] e1);
        @(negedge clk);
        v0 = a0; v1 = a1; ordy = r;
        #1;
        chk("in_ready0", 64'(rdy0), 64'(e0));
        chk("in_ready1", 64'(rdy1), 64'(e1));
        if (e0 != 0) q0.push_back({oh2i(e0), d[oh2i(e0)]});
        if (e1 != 0) q1.push_back({oh2i(e1), d[oh2i(e1)]});
    endtask

    task automatic reset_chk(input string name);
        chk({name, "_valid0"}, 64'(ov0), 64'(0));
        chk({name, "_data0"}, 64'(od0), 64'(0));
        chk({name, "_sel0"}, 64'(os0), 64'(0));
        chk({name, "_valid1"}, 64'(ov1), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v0 = '0; v1 = '0; ordy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 reset_chk("reset");
    endtask

    // monitors: a word leaves the output stage on a rising edge with out_valid & out_ready and no reset
    always begin
        @(negedge clk);
        #2;
        if (!rst && ov0 && ordy) begin
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL out0_unexpected: got %h expected nothing", {os0, od0});
            end else chk("out0", 64'({os0, od0}), 64'(q0.pop_front()));
        end
    end
    always begin
        @(negedge clk);
        #2;
        if (!rst && ov1 && ordy) begin
            if (q1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL out1_unexpected: got %h expected nothing", {os1, od1});
            end else chk("out1", 64'({os1, od1}), 64'(q1.pop_front()));
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 32'hC0DE_0000 | 32'(i);
        do_reset();
        // single request, other channels carry X which must not leak
        d[0] = 32'hDEADBEEF; d[1] = 'x; d[2] = 'x; d[3] = 'x;
        step(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        chk("t1_valid", 64'(ov0), 64'(1));
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) d[i] = 32'hC0DE_0000 | 32'(i);
        chk("t1_empty", 64'(ov0), 64'(0));
        // round-robin fairness from a fresh pointer
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'b0000, 1'b1, 4'b0001 << (i % 4), 4'b0000);
            if (i > 0) chk("t2_valid", 64'(ov0), 64'(1));
        end
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        // fixed priority: ch1 always beats ch2/ch3, then ch2 beats ch3
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b1110, 1'b1, 4'b0000, 4'b0010);
        step(4'b0000, 4'b1100, 1'b1, 4'b0000, 4'b0100);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        // backpressure: fill with ch0 (ptr -> 1), hold, then release
        step(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000);
            chk("t4_frozen", 64'({ov0, os0, od0}), 64'({1'b1, 2'd0, 32'hC0DE_0000}));
        end
        step(4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000);
        // ptr = 3 now: wrap to ch0, then ch1
        step(4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0000);
        step(4'b0011, 4'b0000, 1'b1, 4'b0010, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        // ptr = 2: fill, then reset while full and all requesting
        step(4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0000);
        @(negedge clk);
        rst = 1'b1; v0 = 4'b1111; ordy = 1'b1;
        q0.delete();
        @(negedge clk);
        rst = 1'b0; v0 = 4'b0000;
        #1 reset_chk("t6");
        step(4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        @(negedge clk);
        #3;
        chk("q0_drained", 64'(q0.size()), 64'(0));
        chk("q1_drained", 64'(q1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
